// File: rtl/line_buffer_pkg.sv
// Shared defaults for line_buffer so chained instances and the bench agree on geometry.
package line_buffer_pkg;

    localparam int LB_KERNEL_SIZE = 3;
    localparam int LB_DATA_SIZE   = 8;
    localparam int LB_ROW_SIZE    = 28;

endpackage

// File: rtl/line_buffer.sv
// Row-deep pixel shift register exposing the newest KERNEL_SIZE taps and a row-delayed pixel.
// Outputs are registers (one edge from accept to tap 0); no backpressure, data_valid gaps simply hold state.
module line_buffer
    import line_buffer_pkg::*;
#(
    parameter int KERNEL_SIZE = LB_KERNEL_SIZE,
    parameter int DATA_SIZE   = LB_DATA_SIZE,
    parameter int ROW_SIZE    = LB_ROW_SIZE
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             data_valid,
    input  logic [DATA_SIZE-1:0]             pixel_in,
    output logic [DATA_SIZE-1:0]             pixel_out,
    output logic [KERNEL_SIZE*DATA_SIZE-1:0] conv_row_out,
    output logic                             row_full
);

    localparam int CNT_W = $clog2(ROW_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROW_SIZE);

    logic [DATA_SIZE-1:0] sr_q [ROW_SIZE];
    logic [DATA_SIZE-1:0] sr_d [ROW_SIZE];
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (data_valid) begin
            sr_d[0] = pixel_in;
            for (int i = 1; i < ROW_SIZE; i++) begin
                sr_d[i] = sr_q[i-1];
            end
            // Fill count saturates so row_full stays high for arbitrarily long streams.
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROW_SIZE; i++) begin
                sr_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign pixel_out = sr_q[ROW_SIZE-1];
    assign row_full  = (cnt_q == CNT_MAX);

    for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_tap
        assign conv_row_out[k*DATA_SIZE +: DATA_SIZE] = sr_q[k];
    end

endmodule

// File: tb/tb_line_buffer.sv
// Random and directed stimulus against a queue-based history model of accepted pixels.
module tb_line_buffer;
    import line_buffer_pkg::*;

    localparam int KS = LB_KERNEL_SIZE;
    localparam int DW = LB_DATA_SIZE;
    localparam int RS = LB_ROW_SIZE;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              data_valid = 1'b0;
    logic [DW-1:0]     pixel_in = '0;
    logic [DW-1:0]     pixel_out;
    logic [KS*DW-1:0]  conv_row_out;
    logic              row_full;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] hist[$];

    line_buffer #(
        .KERNEL_SIZE(KS),
        .DATA_SIZE  (DW),
        .ROW_SIZE   (RS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_valid  (data_valid),
        .pixel_in    (pixel_in),
        .pixel_out   (pixel_out),
        .conv_row_out(conv_row_out),
        .row_full    (row_full)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [KS*DW-1:0] exp_conv;
        logic [DW-1:0]    exp_po;
        int               n;
        n        = hist.size();
        exp_conv = '0;
        for (int k = 0; k < KS; k++) begin
            if (n - 1 - k >= 0) exp_conv[k*DW +: DW] = hist[n-1-k];
        end
        exp_po = (n >= RS) ? hist[n-RS] : '0;
        check("model_conv", 64'(conv_row_out), 64'(exp_conv));
        check("model_pout", 64'(pixel_out), 64'(exp_po));
        check("model_full", 64'(row_full), 64'(n >= RS));
    endtask

    task automatic step(input logic v, input logic [DW-1:0] p);
        @(negedge clock);
        data_valid = v;
        pixel_in   = p;
        @(posedge clock);
        if (v) hist.push_back(p);
        #1;
        check_model();
    endtask

    // Called at posedge+1: reset rises between edges, then an edge with data_valid high is held off.
    task automatic do_reset();
        data_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        hist.delete();
        check("rst_conv", 64'(conv_row_out), 64'd0);
        check("rst_pout", 64'(pixel_out), 64'd0);
        check("rst_full", 64'(row_full), 64'd0);
        data_valid = 1'b1;
        pixel_in   = 8'hAB;
        @(posedge clock);
        #1;
        check("rst_hold_conv", 64'(conv_row_out), 64'd0);
        check("rst_hold_full", 64'(row_full), 64'd0);
        @(negedge clock);
        reset      = 1'b0;
        data_valid = 1'b0;
    endtask

    initial begin
        do_reset();

        // Counting stream 0..99
        for (int i = 0; i < 100; i++) begin
            step(1'b1, DW'(i));
            if (i == 2)  check("conv_e3", 64'(conv_row_out), 64'h000102);
            if (i == 9)  check("conv_e10", 64'(conv_row_out), 64'h070809);
            if (i == 27) check("pout_e28", 64'(pixel_out), 64'd0);
            if (i == 28) check("pout_e29", 64'(pixel_out), 64'd1);
            if (i == 99) check("pout_e100", 64'(pixel_out), 64'd72);
            if (i == 26) check("full_e27", 64'(row_full), 64'd0);
            if (i >= 27) check("full_hold", 64'(row_full), 64'd1);
        end

        // Gap in data_valid with garbage on pixel_in
        @(posedge clock);
        #1;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i));
        for (int g = 0; g < 5; g++) begin
            step(1'b0, 8'hFF);
            check("gap_conv", 64'(conv_row_out), 64'h020304);
        end
        for (int i = 5; i < 10; i++) step(1'b1, DW'(i));
        check("resume_conv", 64'(conv_row_out), 64'h070809);

        // Mid-stream reset, then refill from zero
        for (int i = 10; i < 40; i++) step(1'b1, DW'(i));
        check("pre_rst_full", 64'(row_full), 64'd1);
        do_reset();
        for (int i = 0; i < RS; i++) begin
            step(1'b1, DW'($urandom));
            if (i == RS - 2) check("refill_not_full", 64'(row_full), 64'd0);
            if (i == RS - 1) check("refill_full", 64'(row_full), 64'd1);
        end

        // Random valid pattern and pixels, with one reset partway
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 3) != 0, DW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
